// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage PipelineCPU.
//
// Resolves the hazards operand forwarding cannot: load-use stalls,
// taken-branch / jump flushes and data-memory wait freezes. Drives the
// write enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and
// MEM/WR. Multi-cycle stalls are tracked in a small FSM.
//
// Parameters:
//   LU_DEPTH      load-use stall length in cycles (1..3)
// Inputs:
//   clk, rst      pipeline clock, synchronous active-high reset
//   MemRead_EX    EX-stage instruction is a load
//   rw_EX         EX-stage destination register
//   rs_ID, rt_ID  ID-stage source registers
//   RtUsed_ID     ID-stage instruction reads rt
//   Jump_ID       jump decoded in ID
//   Branch_MEM    branch resolved taken in MEM
//   MemAcc_MEM    MEM-stage instruction accesses data memory
//   dmem_ready    data memory completes access this cycle
// Outputs:
//   PCWr, IFIDWr, IDEXWr, EXMEMWr             pipeline write enables
//   IFID_flush, IDEX_flush, EXMEM_flush       flush / bubble controls
//   MEMWR_bubble                              bubble into MEM/WR
//   hz_state                                  0 RUN, 1 LU_STALL, 2 MEM_WAIT
//   stall_cycles, flush_count                 performance counters
//
// Build option: define HAZARD_PERF_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.

module hazard_ctrl #(
  parameter int unsigned LU_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_EX,
  input  logic [4:0]  rw_EX,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        RtUsed_ID,
  input  logic        Jump_ID,
  input  logic        Branch_MEM,
  input  logic        MemAcc_MEM,
  input  logic        dmem_ready,
  output logic        PCWr,
  output logic        IFIDWr,
  output logic        IDEXWr,
  output logic        EXMEMWr,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        MEMWR_bubble,
  output logic [1:0]  hz_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // lu_cnt holds the number of LU_STALL cycles still to come after the
  // current one, so entering LU_STALL loads LU_DEPTH-2.
  localparam logic [1:0] LU_INIT = (LU_DEPTH > 1) ? 2'(LU_DEPTH - 2) : 2'd0;

  state_t     state, state_nx;
  state_t     ret, ret_nx;
  state_t     eff;
  logic [1:0] lu_cnt, lu_cnt_nx;
  logic       lu_hit;
  logic       waiting;
  logic       freeze;

  assign lu_hit = MemRead_EX && (rw_EX != 5'd0) &&
                  ((rw_EX == rs_ID) || (RtUsed_ID && (rw_EX == rt_ID)));

  // While parked in MEM_WAIT the MEM stage is frozen, so only dmem_ready
  // decides whether the freeze continues.
  assign waiting = (state == MEM_WAIT);
  assign freeze  = waiting ? !dmem_ready : (MemAcc_MEM && !dmem_ready);

  // On the release cycle of MEM_WAIT the rules are evaluated as if the
  // FSM were back in the state it was frozen from.
  assign eff = waiting ? ret : state;

  assign hz_state = state;

  always_comb begin
    PCWr         = 1'b1;
    IFIDWr       = 1'b1;
    IDEXWr       = 1'b1;
    EXMEMWr      = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_flush  = 1'b0;
    MEMWR_bubble = 1'b0;
    state_nx     = state;
    ret_nx       = ret;
    lu_cnt_nx    = lu_cnt;

    if (rst) begin
      state_nx  = RUN;
      ret_nx    = RUN;
      lu_cnt_nx = '0;
    end else if (!(state inside {RUN, LU_STALL, MEM_WAIT})) begin
      state_nx = RUN;
      ret_nx   = RUN;
    end else if (freeze) begin
      PCWr         = 1'b0;
      IFIDWr       = 1'b0;
      IDEXWr       = 1'b0;
      EXMEMWr      = 1'b0;
      MEMWR_bubble = 1'b1;
      state_nx     = MEM_WAIT;
      if (!waiting) begin
        ret_nx = (state == LU_STALL) ? LU_STALL : RUN;
      end
    end else begin
      state_nx = RUN;
      ret_nx   = RUN;
      if (Branch_MEM) begin
        IFID_flush  = 1'b1;
        IDEX_flush  = 1'b1;
        EXMEM_flush = 1'b1;
        lu_cnt_nx   = '0;
      end else if (eff == LU_STALL) begin
        PCWr       = 1'b0;
        IFIDWr     = 1'b0;
        IDEX_flush = 1'b1;
        if (lu_cnt != 2'd0) begin
          state_nx  = LU_STALL;
          lu_cnt_nx = lu_cnt - 2'd1;
        end
      end else if ((eff == RUN) && lu_hit) begin
        PCWr       = 1'b0;
        IFIDWr     = 1'b0;
        IDEX_flush = 1'b1;
        if (LU_DEPTH > 1) begin
          state_nx  = LU_STALL;
          lu_cnt_nx = LU_INIT;
        end
      end else if ((eff == RUN) && Jump_ID) begin
        IFID_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      ret    <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nx;
      ret    <= ret_nx;
      lu_cnt <= lu_cnt_nx;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PCWr) begin
        stall_q <= stall_q + 32'd1;
      end
      if (IFID_flush || IDEX_flush || EXMEM_flush) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {PCWr,IFIDWr,IDEXWr,EXMEMWr,IFID_flush,IDEX_flush,EXMEM_flush,MEMWR_bubble}
  localparam logic [7:0] O_IDLE   = 8'b1111_0000;
  localparam logic [7:0] O_FREEZE = 8'b0000_0001;
  localparam logic [7:0] O_BRANCH = 8'b1111_1110;
  localparam logic [7:0] O_LU     = 8'b0011_0100;
  localparam logic [7:0] O_JUMP   = 8'b1111_1000;

  logic clk = 1'b0;
  logic rst;
  logic MemRead_EX, RtUsed_ID, Jump_ID, Branch_MEM, MemAcc_MEM, dmem_ready;
  logic [4:0] rw_EX, rs_ID, rt_ID;

  logic [1:0][7:0]  ob;
  logic [1:0][1:0]  hz;
  logic [1:0][31:0] sc;
  logic [1:0][31:0] fc;

  // model state, index 0 -> LU_DEPTH=1 DUT, index 1 -> LU_DEPTH=3 DUT
  int          m_left [2];
  bit          m_wait [2];
  bit          m_frz  [2];
  bit          m_lu   [2];
  logic [31:0] m_sc   [2];
  logic [31:0] m_fc   [2];
  logic [7:0]  e_o    [2];
  logic [1:0]  e_hz   [2];
  logic [31:0] e_sc   [2];
  logic [31:0] e_fc   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .MemRead_EX(MemRead_EX), .rw_EX(rw_EX), .rs_ID(rs_ID),
    .rt_ID(rt_ID), .RtUsed_ID(RtUsed_ID), .Jump_ID(Jump_ID), .Branch_MEM(Branch_MEM),
    .MemAcc_MEM(MemAcc_MEM), .dmem_ready(dmem_ready),
    .PCWr(ob[0][7]), .IFIDWr(ob[0][6]), .IDEXWr(ob[0][5]), .EXMEMWr(ob[0][4]),
    .IFID_flush(ob[0][3]), .IDEX_flush(ob[0][2]), .EXMEM_flush(ob[0][1]),
    .MEMWR_bubble(ob[0][0]), .hz_state(hz[0]), .stall_cycles(sc[0]), .flush_count(fc[0])
  );

  hazard_ctrl #(.LU_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .MemRead_EX(MemRead_EX), .rw_EX(rw_EX), .rs_ID(rs_ID),
    .rt_ID(rt_ID), .RtUsed_ID(RtUsed_ID), .Jump_ID(Jump_ID), .Branch_MEM(Branch_MEM),
    .MemAcc_MEM(MemAcc_MEM), .dmem_ready(dmem_ready),
    .PCWr(ob[1][7]), .IFIDWr(ob[1][6]), .IDEXWr(ob[1][5]), .EXMEMWr(ob[1][4]),
    .IFID_flush(ob[1][3]), .IDEX_flush(ob[1][2]), .EXMEM_flush(ob[1][1]),
    .MEMWR_bubble(ob[1][0]), .hz_state(hz[1]), .stall_cycles(sc[1]), .flush_count(fc[1])
  );

  task automatic clear_inputs();
    rst = 1'b0; MemRead_EX = 1'b0; RtUsed_ID = 1'b0; Jump_ID = 1'b0;
    Branch_MEM = 1'b0; MemAcc_MEM = 1'b0; dmem_ready = 1'b1;
    rw_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
  endtask

  // Model: m_left = stall cycles still owed (freeze cycles not counted),
  // m_wait = currently parked behind a data-memory wait.
  task automatic predict();
    #1;
    for (int d = 0; d < 2; d++) begin
      m_lu[d]  = MemRead_EX && (rw_EX != 5'd0) &&
                 ((rw_EX == rs_ID) || (RtUsed_ID && (rw_EX == rt_ID)));
      m_frz[d] = m_wait[d] ? !dmem_ready : (MemAcc_MEM && !dmem_ready);
      e_hz[d]  = m_wait[d] ? 2'd2 : ((m_left[d] > 0) ? 2'd1 : 2'd0);
      if (rst)                          e_o[d] = O_IDLE;
      else if (m_frz[d])                e_o[d] = O_FREEZE;
      else if (Branch_MEM)              e_o[d] = O_BRANCH;
      else if (m_left[d] > 0 || m_lu[d]) e_o[d] = O_LU;
      else if (Jump_ID)                 e_o[d] = O_JUMP;
      else                              e_o[d] = O_IDLE;
      e_sc[d] = PERF ? m_sc[d] : 32'd0;
      e_fc[d] = PERF ? m_fc[d] : 32'd0;
    end
  endtask

  task automatic advance();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_left[d] = 0; m_wait[d] = 1'b0; m_sc[d] = '0; m_fc[d] = '0;
      end else begin
        if (!e_o[d][7]) m_sc[d] = m_sc[d] + 32'd1;
        if (|e_o[d][3:1]) m_fc[d] = m_fc[d] + 32'd1;
        if (m_frz[d]) m_wait[d] = 1'b1;
        else begin
          m_wait[d] = 1'b0;
          if (Branch_MEM)        m_left[d] = 0;
          else if (m_left[d] > 0) m_left[d] = m_left[d] - 1;
          else if (m_lu[d])      m_left[d] = (d == 0) ? 0 : 2;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst = 1'b1; MemRead_EX = 1'b1; rw_EX = 5'd4; rs_ID = 5'd4; Jump_ID = 1'b1;
      Branch_MEM = 1'b1; MemAcc_MEM = 1'b1; dmem_ready = 1'b0;
      predict();
      for (int d = 0; d < 2; d++) begin
        total++; if (ob[d] !== O_IDLE) begin bad++; $display("FAIL reset_outs dut%0d cyc%0d got=%b exp=%b", d, cyc, ob[d], O_IDLE); end
        total++; if (hz[d] !== 2'd0) begin bad++; $display("FAIL reset_hz dut%0d got=%0d exp=0", d, hz[d]); end
        total++; if (sc[d] !== 32'd0 || fc[d] !== 32'd0) begin bad++; $display("FAIL reset_cnt dut%0d got=%0d/%0d exp=0/0", d, sc[d], fc[d]); end
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    // step 0: rs hit, 1-4: hold off, 5: rt hit with RtUsed=0, 6: rw_EX=0
    for (int s = 0; s < 8; s++) begin
      clear_inputs();
      case (s)
        0: begin MemRead_EX = 1'b1; rw_EX = 5'd5; rs_ID = 5'd5; end
        5: begin MemRead_EX = 1'b1; rw_EX = 5'd7; rt_ID = 5'd7; RtUsed_ID = 1'b0; rs_ID = 5'd1; end
        6: begin MemRead_EX = 1'b1; rw_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0; RtUsed_ID = 1'b1; end
        default: ;
      endcase
      predict();
      for (int d = 0; d < 2; d++) begin
        total++; if (ob[d] !== e_o[d]) begin bad++; $display("FAIL lu_outs dut%0d cyc%0d got=%b exp=%b", d, cyc, ob[d], e_o[d]); end
        total++; if (hz[d] !== e_hz[d]) begin bad++; $display("FAIL lu_hz dut%0d cyc%0d got=%0d exp=%0d", d, cyc, hz[d], e_hz[d]); end
        total++; if (sc[d] !== e_sc[d]) begin bad++; $display("FAIL lu_stallcnt dut%0d cyc%0d got=%0d exp=%0d", d, cyc, sc[d], e_sc[d]); end
      end
      if (s == 0) begin
        total++; if (ob[0] !== O_LU) begin bad++; $display("FAIL lu_rs_anchor got=%b exp=%b", ob[0], O_LU); end
      end
      if (s == 1) begin
        total++; if (ob[0] !== O_IDLE || hz[0] !== 2'd0) begin bad++; $display("FAIL lu_depth1_release got=%b/%0d exp=%b/0", ob[0], hz[0], O_IDLE); end
      end
      advance();
    end
    // rt hit on the depth-3 unit: three stall cycles
    for (int s = 0; s < 5; s++) begin
      clear_inputs();
      if (s == 0) begin MemRead_EX = 1'b1; rw_EX = 5'd7; rt_ID = 5'd7; RtUsed_ID = 1'b1; rs_ID = 5'd2; end
      predict();
      for (int d = 0; d < 2; d++) begin
        total++; if (ob[d] !== e_o[d]) begin bad++; $display("FAIL lu_rt_outs dut%0d cyc%0d got=%b exp=%b", d, cyc, ob[d], e_o[d]); end
        total++; if (hz[d] !== e_hz[d]) begin bad++; $display("FAIL lu_rt_hz dut%0d cyc%0d got=%0d exp=%0d", d, cyc, hz[d], e_hz[d]); end
      end
      if (s < 3) begin
        total++; if (ob[1] !== O_LU) begin bad++; $display("FAIL lu_rt_depth3_stall step%0d got=%b exp=%b", s, ob[1], O_LU); end
      end
      advance();
    end
  endtask

  // Freeze at step f (a stall cycle) for nfz cycles, optional branch at step br.
  task automatic test_freeze_branch(input int f, input int nfz, input int br, input string tag);
    for (int s = 0; s < 12; s++) begin
      clear_inputs();
      if (s == 0) begin MemRead_EX = 1'b1; rw_EX = 5'd9; rs_ID = 5'd9; end
      if (s >= f && s < f + nfz) begin MemAcc_MEM = 1'b1; dmem_ready = 1'b0; end
      if (s == br) Branch_MEM = 1'b1;
      if (s == br + 1) begin Jump_ID = 1'b1; Branch_MEM = 1'b1; end
      if (s == br + 2) Jump_ID = 1'b1;
      predict();
      for (int d = 0; d < 2; d++) begin
        total++; if (ob[d] !== e_o[d]) begin bad++; $display("FAIL %s_outs dut%0d cyc%0d got=%b exp=%b", tag, d, cyc, ob[d], e_o[d]); end
        total++; if (hz[d] !== e_hz[d]) begin bad++; $display("FAIL %s_hz dut%0d cyc%0d got=%0d exp=%0d", tag, d, cyc, hz[d], e_hz[d]); end
        total++; if (sc[d] !== e_sc[d] || fc[d] !== e_fc[d]) begin bad++; $display("FAIL %s_cnt dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", tag, d, cyc, sc[d], fc[d], e_sc[d], e_fc[d]); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int s = 0; s < 6; s++) begin
      clear_inputs();
      if (s == 0) begin MemRead_EX = 1'b1; rw_EX = 5'd3; rt_ID = 5'd3; RtUsed_ID = 1'b1; end
      if (s == 1 || s == 2) begin MemAcc_MEM = 1'b1; dmem_ready = 1'b0; end
      if (s == 4) rst = 1'b1;
      predict();
      for (int d = 0; d < 2; d++) begin
        total++; if (ob[d] !== e_o[d]) begin bad++; $display("FAIL rstmid_outs dut%0d cyc%0d got=%b exp=%b", d, cyc, ob[d], e_o[d]); end
        total++; if (hz[d] !== e_hz[d]) begin bad++; $display("FAIL rstmid_hz dut%0d cyc%0d got=%0d exp=%0d", d, cyc, hz[d], e_hz[d]); end
        total++; if (sc[d] !== e_sc[d] || fc[d] !== e_fc[d]) begin bad++; $display("FAIL rstmid_cnt dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", d, cyc, sc[d], fc[d], e_sc[d], e_fc[d]); end
      end
      if (s == 5) begin
        total++; if (hz[1] !== 2'd0 || ob[1] !== O_IDLE) begin bad++; $display("FAIL rstmid_anchor got=%0d/%b exp=0/%b", hz[1], ob[1], O_IDLE); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2000; s++) begin
      rst        = ($urandom_range(0, 99) < 1);
      MemRead_EX = ($urandom_range(0, 99) < 40);
      rw_EX      = 5'($urandom_range(0, 3));
      rs_ID      = 5'($urandom_range(0, 3));
      rt_ID      = 5'($urandom_range(0, 3));
      RtUsed_ID  = ($urandom_range(0, 99) < 50);
      Jump_ID    = ($urandom_range(0, 99) < 20);
      Branch_MEM = ($urandom_range(0, 99) < 10);
      MemAcc_MEM = ($urandom_range(0, 99) < 30);
      dmem_ready = ($urandom_range(0, 99) < 60);
      predict();
      for (int d = 0; d < 2; d++) begin
        total++; if (ob[d] !== e_o[d]) begin bad++; $display("FAIL rand_outs dut%0d cyc%0d got=%b exp=%b", d, cyc, ob[d], e_o[d]); end
        total++; if (hz[d] !== e_hz[d]) begin bad++; $display("FAIL rand_hz dut%0d cyc%0d got=%0d exp=%0d", d, cyc, hz[d], e_hz[d]); end
        total++; if (sc[d] !== e_sc[d] || fc[d] !== e_fc[d]) begin bad++; $display("FAIL rand_cnt dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", d, cyc, sc[d], fc[d], e_sc[d], e_fc[d]); end
      end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_wait[d] = 1'b0; m_sc[d] = '0; m_fc[d] = '0;
    end
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_freeze_branch(1, 4, 99, "freeze_lu");
    test_freeze_branch(99, 0, 0, "branch_cancel");
    test_freeze_branch(1, 2, 1, "freeze_branch");
    test_freeze_branch(99, 0, 6, "jump_branch");
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
